irrigation_sequencer: RTL and testbench

//  Registered sequencer/arbiter for the irrigation actuators. Takes the raw requests from the

---
 rtl/irrigation_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_irrigation_sequencer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irrigation_sequencer.sv
// irrigation_sequencer
// Registered sequencer for the irrigation actuators. Spray (Bs) and drip (Vs)
// share one water source: they are round-robin arbitrated, held for a minimum
// on-time, pre-empted after a maximum on-time when the other side waits, and
// separated by a break-before-make dead time. The inlet valve (Ve) runs
// independently under a fill-timeout watchdog with a sticky fault.

module irrigation_sequencer #(
    parameter int unsigned MIN_ON       = 8,
    parameter int unsigned MAX_ON       = 64,
    parameter int unsigned DEAD         = 4,
    parameter int unsigned FILL_TIMEOUT = 1000,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_spray,
    input  logic       req_drip,
    input  logic       req_fill,
    input  logic       error,
    input  logic       fault_clr,
    output logic       Bs,
    output logic       Vs,
    output logic       Ve,
    output logic       busy,
    output logic       fill_fault,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SPRAY = 2'd1,
        S_DRIP  = 2'd2,
        S_DEAD  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_ON_C    = CNT_W'(MIN_ON);
    localparam logic [CNT_W-1:0] MAX_ON_C    = CNT_W'(MAX_ON);
    localparam logic [CNT_W-1:0] DEAD_C      = CNT_W'(DEAD);
    localparam logic [CNT_W-1:0] FILL_LAST_C = CNT_W'(FILL_TIMEOUT - 1);

    // Arbitration / hold state
    state_e           state_q,     state_d;
    logic [CNT_W-1:0] on_cnt_q,    on_cnt_d;
    logic [CNT_W-1:0] dead_cnt_q,  dead_cnt_d;
    logic             last_drip_q, last_drip_d;   // 1: drip was served most recently

    // Registered actuator drives
    logic             bs_q, bs_d;
    logic             vs_q, vs_d;

    // Inlet valve watchdog
    logic             ve_q,         ve_d;
    logic [CNT_W-1:0] fill_cnt_q,   fill_cnt_d;
    logic             fill_fault_q, fill_fault_d;
    logic             fill_timeout;

    // Grant-release helpers for the active owner
    logic             own_req;
    logic             other_req;
    logic             min_met;
    logic             max_met;
    logic             grant_release;

    // Pick up the active owner's own/other requests and the hold thresholds
    always_comb begin
        own_req   = 1'b0;
        other_req = 1'b0;
        if (state_q == S_SPRAY) begin
            own_req   = req_spray;
            other_req = req_drip;
        end else if (state_q == S_DRIP) begin
            own_req   = req_drip;
            other_req = req_spray;
        end
        min_met       = (on_cnt_q >= MIN_ON_C);
        max_met       = (on_cnt_q >= MAX_ON_C);
        // error ends a grant immediately; otherwise the minimum on-time must elapse
        // before a dropped request releases, and the maximum on-time yields to a waiter
        grant_release = error | (~own_req & min_met) | (other_req & max_met);
    end

    // Next-state logic for the spray/drip sequencer
    always_comb begin
        state_d     = state_q;
        on_cnt_d    = on_cnt_q;
        dead_cnt_d  = dead_cnt_q;
        last_drip_d = last_drip_q;

        unique case (state_q)
            S_IDLE: begin
                on_cnt_d   = '0;
                dead_cnt_d = '0;
                if (!error) begin
                    // A tie goes to whichever side was not served last
                    if (req_spray && (!req_drip || last_drip_q)) begin
                        state_d     = S_SPRAY;
                        on_cnt_d    = ONE_C;
                        last_drip_d = 1'b0;
                    end else if (req_drip) begin
                        state_d     = S_DRIP;
                        on_cnt_d    = ONE_C;
                        last_drip_d = 1'b1;
                    end
                end
            end

            S_SPRAY, S_DRIP: begin
                if (grant_release) begin
                    state_d    = S_DEAD;
                    on_cnt_d   = '0;
                    dead_cnt_d = ONE_C;
                end else if (on_cnt_q < MAX_ON_C) begin
                    on_cnt_d = on_cnt_q + ONE_C;
                end
            end

            S_DEAD: begin
                // Dead time counts its own cycles; error has nothing further to do here
                if (dead_cnt_q >= DEAD_C) begin
                    state_d    = S_IDLE;
                    dead_cnt_d = '0;
                end else begin
                    dead_cnt_d = dead_cnt_q + ONE_C;
                end
            end

            default: begin
                state_d    = S_IDLE;
                on_cnt_d   = '0;
                dead_cnt_d = '0;
            end
        endcase
    end

    // Actuator drives follow the next state so Bs/Vs are registered with the state
    always_comb begin
        bs_d = (state_d == S_SPRAY);
        vs_d = (state_d == S_DRIP);
    end

    // Inlet valve drive, fill counter and sticky timeout fault
    always_comb begin
        fill_timeout = ve_q && (fill_cnt_q == FILL_LAST_C);

        // A clear in the timeout cycle wins: fault stays low and the valve keeps running
        if (fault_clr) begin
            fill_fault_d = 1'b0;
        end else begin
            fill_fault_d = fill_fault_q | fill_timeout;
        end

        ve_d = req_fill & ~error & (fault_clr | (~fill_fault_q & ~fill_timeout));

        if (fault_clr || !ve_q || fill_timeout) begin
            fill_cnt_d = '0;
        end else begin
            fill_cnt_d = fill_cnt_q + ONE_C;
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            on_cnt_q     <= '0;
            dead_cnt_q   <= '0;
            last_drip_q  <= 1'b1;
            bs_q         <= 1'b0;
            vs_q         <= 1'b0;
            ve_q         <= 1'b0;
            fill_cnt_q   <= '0;
            fill_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            on_cnt_q     <= on_cnt_d;
            dead_cnt_q   <= dead_cnt_d;
            last_drip_q  <= last_drip_d;
            bs_q         <= bs_d;
            vs_q         <= vs_d;
            ve_q         <= ve_d;
            fill_cnt_q   <= fill_cnt_d;
            fill_fault_q <= fill_fault_d;
        end
    end

    assign Bs         = bs_q;
    assign Vs         = vs_q;
    assign Ve         = ve_q;
    assign fill_fault = fill_fault_q;
    assign busy       = (state_q != S_IDLE);
    assign state      = state_q;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Testbench for irrigation_sequencer: directed scenarios plus a randomized run,
// all checked against a behavioural model of the actuator rules.

module tb_irrigation_sequencer;

    localparam int MIN_ON       = 4;
    localparam int MAX_ON       = 8;
    localparam int DEAD         = 2;
    localparam int FILL_TIMEOUT = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_spray, req_drip, req_fill, error, fault_clr;
    logic       Bs, Vs, Ve, busy, fill_fault;
    logic [1:0] state;
    logic [6:0] dut_vec;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Behavioural model: who owns the water source, how long it has held it,
    // remaining dead-time cycles, tie preference, and the inlet valve run length.
    int m_owner;        // 0 none, 1 spray, 2 drip
    int m_held;
    int m_gap;
    bit m_pref_spray;
    bit m_ve;
    int m_run;
    bit m_fault;

    always #5 clock = ~clock;

    irrigation_sequencer #(
        .MIN_ON(MIN_ON),
        .MAX_ON(MAX_ON),
        .DEAD(DEAD),
        .FILL_TIMEOUT(FILL_TIMEOUT),
        .CNT_W(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req_spray(req_spray),
        .req_drip(req_drip),
        .req_fill(req_fill),
        .error(error),
        .fault_clr(fault_clr),
        .Bs(Bs),
        .Vs(Vs),
        .Ve(Ve),
        .busy(busy),
        .fill_fault(fill_fault),
        .state(state)
    );

    assign dut_vec = {Bs, Vs, Ve, busy, fill_fault, state};

    task automatic model_reset();
        m_owner      = 0;
        m_held       = 0;
        m_gap        = 0;
        m_pref_spray = 1'b1;
        m_ve         = 1'b0;
        m_run        = 0;
        m_fault      = 1'b0;
    endtask

    task automatic model_step();
        bit own, oth, timeout, new_ve;
        if (m_owner != 0) begin
            own = (m_owner == 1) ? req_spray : req_drip;
            oth = (m_owner == 1) ? req_drip : req_spray;
            if (error || (!own && m_held >= MIN_ON) || (oth && m_held >= MAX_ON)) begin
                m_owner = 0;
                m_gap   = DEAD;
            end else begin
                m_held++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (!error && (req_spray || req_drip)) begin
            if (req_spray && req_drip) m_owner = m_pref_spray ? 1 : 2;
            else                       m_owner = req_spray ? 1 : 2;
            m_held       = 1;
            m_pref_spray = (m_owner == 2);
        end

        timeout = m_ve && (m_run == FILL_TIMEOUT);
        new_ve  = req_fill && !error && (fault_clr || (!m_fault && !timeout));
        if (fault_clr)    m_fault = 1'b0;
        else if (timeout) m_fault = 1'b1;
        if (!new_ve)                 m_run = 0;
        else if (fault_clr || !m_ve) m_run = 1;
        else                         m_run++;
        m_ve = new_ve;
    endtask

    function automatic logic [6:0] exp_vec();
        logic [1:0] st;
        st = (m_owner != 0) ? 2'(m_owner) : ((m_gap > 0) ? 2'd3 : 2'd0);
        return {m_owner == 1, m_owner == 2, m_ve, st != 2'd0, m_fault, st};
    endfunction

    task automatic tick();
        @(posedge clock);
        if (reset) model_reset();
        else       model_step();
        #1;
        cyc++;
    endtask

    task automatic drive_idle();
        req_spray = 1'b0;
        req_drip  = 1'b0;
        req_fill  = 1'b0;
        error     = 1'b0;
        fault_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        model_reset();
        #2;
        n_cmp++;
        if (dut_vec !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_async: got %b want %b", dut_vec, 7'b0);
        end
        tick();
        tick();
        @(negedge clock);
        reset = 1'b0;
        tick();
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL reset_idle cyc %0d: got %b want %b", cyc, dut_vec, exp_vec());
        end
    endtask

    task automatic test_single_spray();
        int bs_n, dead_n;
        req_spray = 1'b1;
        tick();
        req_spray = 1'b0;
        bs_n   = Bs ? 1 : 0;
        dead_n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL single_spray cyc %0d: got %b want %b", cyc, dut_vec, exp_vec());
            end
            if (Bs) bs_n++;
            if (state == 2'd3) dead_n++;
        end
        n_cmp++;
        if (bs_n != MIN_ON) begin
            n_bad++;
            $display("FAIL single_spray_on_len: got %0d want %0d", bs_n, MIN_ON);
        end
        n_cmp++;
        if (dead_n != DEAD) begin
            n_bad++;
            $display("FAIL single_spray_dead_len: got %0d want %0d", dead_n, DEAD);
        end
    endtask

    task automatic test_round_robin();
        int  p;
        bit  e_bs, e_vs;
        reset     = 1'b1;
        req_spray = 1'b1;
        req_drip  = 1'b1;
        tick();
        @(negedge clock);
        reset = 1'b0;
        // Period: MAX_ON spray + (DEAD+1) gap + MAX_ON drip + (DEAD+1) gap
        for (int t = 1; t <= 48; t++) begin
            tick();
            p    = (t - 1) % (2 * (MAX_ON + DEAD + 1));
            e_bs = (p < MAX_ON);
            e_vs = (p >= MAX_ON + DEAD + 1) && (p < 2 * MAX_ON + DEAD + 1);
            n_cmp++;
            if ({Bs, Vs} !== {e_bs, e_vs}) begin
                n_bad++;
                $display("FAIL round_robin_pattern t %0d: got %b%b want %b%b", t, Bs, Vs, e_bs, e_vs);
            end
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL round_robin cyc %0d: got %b want %b", cyc, dut_vec, exp_vec());
            end
        end
        drive_idle();
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic test_error();
        req_drip = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({Vs, state} !== 3'b1_10) begin
            n_bad++;
            $display("FAIL error_pre_grant: got %b want %b", {Vs, state}, 3'b1_10);
        end
        error = 1'b1;
        tick();
        n_cmp++;
        if ({Vs, state} !== 3'b0_11) begin
            n_bad++;
            $display("FAIL error_drop: got %b want %b", {Vs, state}, 3'b0_11);
        end
        req_spray = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if ((Bs | Vs) !== 1'b0) begin
                n_bad++;
                $display("FAIL error_no_regrant cyc %0d: got Bs=%b Vs=%b want 0", cyc, Bs, Vs);
            end
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL error_model cyc %0d: got %b want %b", cyc, dut_vec, exp_vec());
            end
        end
        drive_idle();
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_fill_timeout();
        int ve_n;
        ve_n     = 0;
        req_fill = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL fill_model cyc %0d: got %b want %b", cyc, dut_vec, exp_vec());
            end
            if (Ve) ve_n++;
            else if (ve_n > 0) break;
        end
        n_cmp++;
        if (ve_n != FILL_TIMEOUT) begin
            n_bad++;
            $display("FAIL fill_on_len: got %0d want %0d", ve_n, FILL_TIMEOUT);
        end
        n_cmp++;
        if (fill_fault !== 1'b1) begin
            n_bad++;
            $display("FAIL fill_fault_set: got %b want 1", fill_fault);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({Ve, fill_fault} !== 2'b01) begin
                n_bad++;
                $display("FAIL fill_fault_hold cyc %0d: got %b want 01", cyc, {Ve, fill_fault});
            end
        end
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        n_cmp++;
        if ({Ve, fill_fault} !== 2'b10) begin
            n_bad++;
            $display("FAIL fill_clr_restart: got %b want 10", {Ve, fill_fault});
        end
        req_fill = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_clr_same_cycle();
        int ve_n;
        req_fill = 1'b1;
        for (int i = 0; i < FILL_TIMEOUT; i++) tick();
        n_cmp++;
        if (Ve !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_pre_ve: got %b want 1", Ve);
        end
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        n_cmp++;
        if ({Ve, fill_fault} !== 2'b10) begin
            n_bad++;
            $display("FAIL clr_wins: got %b want 10", {Ve, fill_fault});
        end
        ve_n = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL clr_model cyc %0d: got %b want %b", cyc, dut_vec, exp_vec());
            end
            if (Ve) ve_n++;
            else break;
        end
        n_cmp++;
        if (ve_n != FILL_TIMEOUT) begin
            n_bad++;
            $display("FAIL clr_count_restart: got %0d want %0d", ve_n, FILL_TIMEOUT);
        end
        req_fill  = 1'b0;
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        req_spray = 1'b1;
        tick();
        tick();
        #3;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({Bs, busy, state} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_mid_drop: got %b want 0000", {Bs, busy, state});
        end
        model_reset();
        req_drip = 1'b1;
        tick();
        @(negedge clock);
        reset = 1'b0;
        tick();
        n_cmp++;
        if ({Bs, Vs} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_mid_tie: got %b want 10", {Bs, Vs});
        end
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL reset_mid_model cyc %0d: got %b want %b", cyc, dut_vec, exp_vec());
        end
        drive_idle();
        for (int i = 0; i < 12; i++) tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            req_spray = ($urandom_range(0, 3) != 0);
            req_drip  = ($urandom_range(0, 2) != 0);
            req_fill  = ($urandom_range(0, 9) < 8);
            error     = ($urandom_range(0, 19) == 0);
            fault_clr = ($urandom_range(0, 24) == 0);
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL random cyc %0d: got %b want %b", cyc, dut_vec, exp_vec());
            end
            n_cmp++;
            if ((Bs & Vs) !== 1'b0) begin
                n_bad++;
                $display("FAIL exclusive cyc %0d: got Bs=%b Vs=%b want not both", cyc, Bs, Vs);
            end
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_single_spray();
        test_round_robin();
        test_error();
        test_fill_timeout();
        test_clr_same_cycle();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
